// File: rtl/mem_pkg.sv
// Constants and types shared by the single-port RAM and the blocks that stream to or from it.
package mem_pkg;

   localparam int MEM_DATA_W = 3;
   localparam int MEM_ADDR_W = 5;
   localparam int MEM_LEN_W  = 6;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } burst_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO with a registered head, used to absorb RAM return data
// while a stream consumer applies backpressure.
module skid_fifo2 #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] slot [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != 2'd0);
   assign head   = slot[rd_ptr];

   // NOTE: the storage is two flops, so it is reset along with the pointers; this keeps head at 0 after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (push) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // The producer's credit scheme must never push into a full FIFO that is not popping.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && !do_pop && count == 2'd2));

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator: issues sequential RAM reads for a (start_addr, len) command and
// streams the returned words out on a valid/ready interface with full backpressure.
module mem_burst_reader
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int LEN_W  = MEM_LEN_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);

   if (RD_LAT != 1) begin : g_rd_lat_check
      $error("mem_burst_reader only supports RD_LAT == 1");
   end

   burst_state_t      state_q;
   burst_state_t      state_d;
   logic [ADDR_W-1:0] rd_addr;
   logic [LEN_W-1:0]  issue_cnt;
   logic [LEN_W-1:0]  rem_cnt;
   logic              inflight;
   logic [1:0]        fifo_count;
   logic [2:0]        credit_used;
   logic              issue;
   logic              pop;
   logic              accept;

   assign pop         = out_valid && out_ready;
   assign accept      = (state_q == IDLE) && start && (len != '0);
   assign credit_used = {1'b0, fifo_count} + {2'b00, inflight};

   // A slot being popped this cycle is free again by the time the new read returns,
   // which is what sustains one word per cycle with out_ready held high.
   assign issue = (state_q == RUN) &&
                  ((credit_used < 3'd2) || (pop && credit_used == 3'd2));

   assign mem_write   = 1'b0;
   assign mem_data_in = '0;
   assign mem_addr    = rd_addr;
   assign out_valid   = (fifo_count != 2'd0);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: defaulting state_d first means no path through the case can infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = (len == '0) ? DONE : RUN;
         RUN:   if (issue && issue_cnt == LEN_W'(1)) state_d = DRAIN;
         DRAIN: if (pop && rem_cnt == LEN_W'(1)) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         RUN, DRAIN: busy = 1'b1;
         DONE:       done = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr   <= '0;
         issue_cnt <= '0;
         rem_cnt   <= '0;
         inflight  <= 1'b0;
      end else begin
         if (accept) begin
            rd_addr   <= start_addr;
            issue_cnt <= len;
            rem_cnt   <= len;
         end else begin
            if (issue) begin
               rd_addr   <= rd_addr + ADDR_W'(1);
               issue_cnt <= issue_cnt - LEN_W'(1);
            end
            if (pop) begin
               rem_cnt <= rem_cnt - LEN_W'(1);
            end
         end
         inflight <= issue;
      end
   end

   // The RAM output is only meaningful the cycle after an issue, so inflight gates the push.
   skid_fifo2 #(
      .WIDTH(DATA_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (inflight),
      .push_data(mem_data_out),
      .pop      (pop),
      .count    (fifo_count),
      .head     (out_data)
   );

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: acts as the RAM and compares the stream against a
// word-queue model of each accepted burst on every falling edge.
module tb_mem_burst_reader;
   import mem_pkg::*;

   localparam int DW = MEM_DATA_W;
   localparam int AW = MEM_ADDR_W;
   localparam int LW = MEM_LEN_W;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   logic [DW-1:0] ram [32];

   always #5 clk = ~clk;

   mem_burst_reader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_addr  (start_addr),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_data_in (mem_data_in),
      .mem_data_out(mem_data_out),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready)
   );

   // Registered-read RAM behaviour.
   always @(posedge clk) mem_data_out <= ram[mem_addr];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
      end
   endtask

   // Model state and logs.
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] out_log [$];
   int            hs_cyc_log [$];
   logic [AW-1:0] addr_log [$];
   bit            m_busy = 0;
   int            m_len = 0;
   int            m_issued = 0;
   int            m_accepted = 0;
   logic [AW-1:0] m_addr_prev = '0;
   bit            done_due = 0;
   bit            rst_due = 0;
   bit            stall_prev = 0;
   logic [DW-1:0] stall_data = '0;
   int            stall_cnt = 0;
   int            cyc = 0;
   int            start_cyc = 0;
   int            first_valid_cyc = 0;
   bit            first_seen = 0;
   int            done_cnt = 0;
   int            done_cyc = 0;

   always @(negedge clk) begin
      bit            busy_now;
      bit            done_now;
      logic [AW-1:0] nxt;
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      cyc++;
      check("mem_write", 32'(mem_write), 32'd0);
      check("mem_data_in", 32'(mem_data_in), 32'd0);
      if (rst_due) begin
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_valid", 32'(out_valid), 32'd0);
         check("rst_done", 32'(done), 32'd0);
      end else begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(done_due));
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (stall_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(stall_data));
         end
         if (!m_busy) check("idle_valid", 32'(out_valid), 32'd0);
         if (m_busy && out_valid && !first_seen) begin
            first_seen = 1;
            first_valid_cyc = cyc;
         end
         if (m_busy && mem_addr != m_addr_prev) begin
            nxt = m_addr_prev + 5'd1;
            check("addr_step", 32'(mem_addr), 32'(nxt));
            addr_log.push_back(m_addr_prev);
            m_issued++;
            check("outstanding_le2", 32'(m_issued - m_accepted <= 2), 32'd1);
            check("issued_le_len", 32'(m_issued <= m_len), 32'd1);
         end
      end
      m_addr_prev = mem_addr;

      // Events that the next rising edge will commit.
      busy_now   = m_busy;
      done_now   = done_due;
      done_due   = 0;
      stall_prev = 0;
      if (reset) begin
         rst_due = 1;
         m_busy  = 0;
         exp_q.delete();
      end else begin
         rst_due = 0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
               w = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(w));
               out_log.push_back(out_data);
               hs_cyc_log.push_back(cyc);
               m_accepted++;
               if (exp_q.size() == 0) begin
                  m_busy   = 0;
                  done_due = 1;
                  check("issued_total", m_issued, m_len);
               end
            end
         end else if (out_valid) begin
            stall_prev = 1;
            stall_data = out_data;
            stall_cnt++;
         end
         if (start && !busy_now && !done_now) begin
            start_cyc = cyc;
            if (len == '0) begin
               done_due = 1;
            end else begin
               m_busy      = 1;
               m_len       = int'(len);
               m_issued    = 0;
               m_accepted  = 0;
               m_addr_prev = start_addr;
               first_seen  = 0;
               for (int i = 0; i < int'(len); i++) begin
                  a = start_addr + AW'(i);
                  exp_q.push_back(ram[a]);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
      start      = 1'b1;
      start_addr = a;
      len        = l;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 300) begin
         step();
         n++;
      end
      check("done_timeout", done_cnt, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int o0;
      int h0;
      int d0;
      int a0;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 32; i++) ram[i] = DW'(i * 5 + 1);
      reset      = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      len        = '0;
      out_ready  = 1'b1;
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_mem_addr", 32'(mem_addr), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      step();

      // Basic two-word burst.
      ram[3] = 3'b110;
      ram[4] = 3'b101;
      o0 = out_log.size();
      h0 = hs_cyc_log.size();
      cmd(5'd3, 6'd2);
      wait_done(1);
      check("t1_word0", 32'(out_log[o0]), 32'b110);
      check("t1_word1", 32'(out_log[o0+1]), 32'b101);
      // start sampled at the edge after start_cyc; valid visible two edges later.
      check("t1_latency", first_valid_cyc - start_cyc, 3);
      check("t1_consecutive", hs_cyc_log[h0+1] - hs_cyc_log[h0], 1);
      check("t1_done_after_last", done_cyc - hs_cyc_log[h0+1], 1);

      // Address wrap 31 -> 0.
      ram[31] = 3'b111;
      ram[0]  = 3'b001;
      o0 = out_log.size();
      a0 = addr_log.size();
      cmd(5'd31, 6'd2);
      wait_done(2);
      check("t2_addr0", 32'(addr_log[a0]), 32'd31);
      check("t2_addr1", 32'(addr_log[a0+1]), 32'd0);
      check("t2_word0", 32'(out_log[o0]), 32'b111);
      check("t2_word1", 32'(out_log[o0+1]), 32'b001);

      // Backpressure with ready pattern 1,0,0,1.
      ram[1] = 3'b010;
      ram[2] = 3'b100;
      o0 = out_log.size();
      stall_cnt = 0;
      cmd(5'd0, 6'd4);
      for (int k = 0; k < 100 && done_cnt < 3; k++) begin
         out_ready = pat[k % 4];
         step();
      end
      check("t3_done", done_cnt, 3);
      out_ready = 1'b1;
      check("t3_count", out_log.size() - o0, 4);
      check("t3_word0", 32'(out_log[o0]), 32'b001);
      check("t3_word1", 32'(out_log[o0+1]), 32'b010);
      check("t3_word2", 32'(out_log[o0+2]), 32'b100);
      check("t3_word3", 32'(out_log[o0+3]), 32'b110);
      check("t3_stalled", 32'(stall_cnt > 0), 32'd1);

      // Zero-length command: no reads, done one cycle later.
      a0 = addr_log.size();
      cmd(5'd5, 6'd0);
      wait_done(4);
      check("t4_done_delay", done_cyc - start_cyc, 1);
      check("t4_no_issue", addr_log.size() - a0, 0);
      check("t4_mem_addr", 32'(mem_addr), 32'd4);

      // Reset after three accepted words of an eight-word burst.
      d0 = done_cnt;
      cmd(5'd8, 6'd8);
      for (int n = 0; n < 100 && m_accepted < 3; n++) step();
      check("t5_accepted", m_accepted, 3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      step();
      step();
      check("t5_no_done", done_cnt, d0);
      o0 = out_log.size();
      cmd(5'd3, 6'd2);
      wait_done(d0 + 1);
      check("t5_word0", 32'(out_log[o0]), 32'b110);
      check("t5_word1", 32'(out_log[o0+1]), 32'b101);

      // Second start during a busy burst is ignored.
      o0 = out_log.size();
      d0 = done_cnt;
      cmd(5'd20, 6'd4);
      start      = 1'b1;
      start_addr = 5'd10;
      len        = 6'd1;
      step();
      start = 1'b0;
      wait_done(d0 + 1);
      step();
      step();
      step();
      check("t6_words", out_log.size() - o0, 4);
      check("t6_dones", done_cnt - d0, 1);

      // Full-RAM burst from address 7 at one word per cycle.
      o0 = out_log.size();
      h0 = hs_cyc_log.size();
      d0 = done_cnt;
      cmd(5'd7, 6'd32);
      wait_done(d0 + 1);
      check("t7_words", out_log.size() - o0, 32);
      check("t7_throughput", hs_cyc_log[hs_cyc_log.size()-1] - hs_cyc_log[h0], 31);
      check("t7_last_addr", 32'(addr_log[addr_log.size()-1]), 32'd6);

      step();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
